// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with one output stage and valid/ready flow control.
// Operand B may come from an internal accumulator so multi-beat frames can be reduced.
module logic_unit_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b1}},
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       inOp,
  input  logic             inAccum,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outY,
  output logic             outZero,
  output logic             outLast,
  output logic [CNT_W-1:0] outBeats
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Handshake: a beat transfers on an edge where valid && ready are both high.
  // inReady = !outValid || outReady, so a full register that is being drained
  // can take a new beat in the same cycle and continuous flow has no bubbles.

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt_inc;

  assign inReady = !out_valid_q || outReady;
  assign accept  = inValid && inReady;
  assign consume = out_valid_q && outReady;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    op_b   = inAccum ? acc_q : inB;
    result = inA;
    case (op_e'(inOp))
      OP_AND:  result = inA & op_b;
      OP_OR:   result = inA | op_b;
      OP_XOR:  result = inA ^ op_b;
      OP_NAND: result = ~(inA & op_b);
      OP_NOR:  result = ~(inA | op_b);
      OP_XNOR: result = ~(inA ^ op_b);
      OP_NOTA: result = ~inA;
      OP_PASS: result = inA;
      default: result = inA;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    last_d      = last_q;
    beats_d     = beats_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = result;
      zero_d      = (result == '0);
      last_d      = inLast;
      beats_d     = cnt_inc;
      // Frame end re-arms the accumulator and counter for the next frame.
      acc_d       = inLast ? ACC_INIT : result;
      cnt_d       = inLast ? '0 : cnt_inc;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      last_q      <= 1'b0;
      beats_q     <= '0;
      acc_q       <= ACC_INIT;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      last_q      <= last_d;
      beats_q     <= beats_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign outValid = out_valid_q;
  assign outY     = y_q;
  assign outZero  = zero_q;
  assign outLast  = last_q;
  assign outBeats = beats_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three instances (8-bit, 8-bit with 2-bit counter, 13-bit)
// exercised by directed scenario tasks and a random valid/ready scoreboard run.
module tb_logic_unit_pipe;

  localparam int NBEATS  = 10000;
  localparam int MAX_CYC = 60000;
  localparam int EW      = 22;  // {y[12:0], last, beats[7:0]}
  localparam logic [7:0] OPS_EXP [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // instance A: WIDTH=8, CNT_W=8
  logic       a_in_valid = 0, a_in_accum = 0, a_in_last = 0, a_out_ready = 0;
  logic [7:0] a_in_a = 0, a_in_b = 0;
  logic [2:0] a_in_op = 0;
  logic       a_in_ready, a_out_valid, a_out_zero, a_out_last;
  logic [7:0] a_out_y, a_out_beats;

  // instance B: WIDTH=8, CNT_W=2
  logic       b_in_valid = 0, b_in_accum = 0, b_in_last = 0, b_out_ready = 0;
  logic [7:0] b_in_a = 0, b_in_b = 0;
  logic [2:0] b_in_op = 0;
  logic       b_in_ready, b_out_valid, b_out_zero, b_out_last;
  logic [7:0] b_out_y;
  logic [1:0] b_out_beats;

  // instance C: WIDTH=13, CNT_W=8
  logic        c_in_valid = 0, c_in_accum = 0, c_in_last = 0, c_out_ready = 0;
  logic [12:0] c_in_a = 0, c_in_b = 0;
  logic [2:0]  c_in_op = 0;
  logic        c_in_ready, c_out_valid, c_out_zero, c_out_last;
  logic [12:0] c_out_y;
  logic [7:0]  c_out_beats;

  logic [7:0]    exp8_q[$];
  logic [EW-1:0] exp_q[$];

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .inValid(a_in_valid), .inReady(a_in_ready),
    .inA(a_in_a), .inB(a_in_b), .inOp(a_in_op), .inAccum(a_in_accum), .inLast(a_in_last),
    .outValid(a_out_valid), .outReady(a_out_ready), .outY(a_out_y), .outZero(a_out_zero),
    .outLast(a_out_last), .outBeats(a_out_beats)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .inValid(b_in_valid), .inReady(b_in_ready),
    .inA(b_in_a), .inB(b_in_b), .inOp(b_in_op), .inAccum(b_in_accum), .inLast(b_in_last),
    .outValid(b_out_valid), .outReady(b_out_ready), .outY(b_out_y), .outZero(b_out_zero),
    .outLast(b_out_last), .outBeats(b_out_beats)
  );

  logic_unit_pipe #(.WIDTH(13), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst(rst), .inValid(c_in_valid), .inReady(c_in_ready),
    .inA(c_in_a), .inB(c_in_b), .inOp(c_in_op), .inAccum(c_in_accum), .inLast(c_in_last),
    .outValid(c_out_valid), .outReady(c_out_ready), .outY(c_out_y), .outZero(c_out_zero),
    .outLast(c_out_last), .outBeats(c_out_beats)
  );

  function automatic logic [12:0] lop(input logic [2:0] op, input logic [12:0] a, input logic [12:0] b);
    case (op)
      3'd0: lop = a & b;
      3'd1: lop = a | b;
      3'd2: lop = a ^ b;
      3'd3: lop = ~(a & b);
      3'd4: lop = ~(a | b);
      3'd5: lop = ~(a ^ b);
      3'd6: lop = ~a;
      default: lop = a;
    endcase
  endfunction

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
    n_checks++; if (a_out_y !== 8'h00) begin n_fail++; $display("FAIL reset_y got=%h exp=00", a_out_y); end
    n_checks++; if (a_out_beats !== 8'd0) begin n_fail++; $display("FAIL reset_beats got=%0d exp=0", a_out_beats); end
    n_checks++; if ({a_out_zero, a_out_last} !== 2'b00) begin n_fail++; $display("FAIL reset_zero_last got=%b exp=00", {a_out_zero, a_out_last}); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    n_checks++; if ({b_out_valid, c_out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_bc_valid got=%b exp=00", {b_out_valid, c_out_valid}); end
  endtask

  task automatic test_ops();
    a_out_ready = 1'b1; a_in_accum = 1'b0; a_in_last = 1'b1;
    a_in_a = 8'hF0; a_in_b = 8'h3C;
    for (int op = 0; op < 8; op++) begin
      a_in_op = 3'(op); a_in_valid = 1'b1;
      tick();
      n_checks++; if (a_out_y !== OPS_EXP[op]) begin n_fail++; $display("FAIL ops_y op=%0d got=%h exp=%h", op, a_out_y, OPS_EXP[op]); end
      n_checks++; if ({a_out_valid, a_out_last, a_out_beats} !== {1'b1, 1'b1, 8'd1}) begin
        n_fail++; $display("FAIL ops_ctl op=%0d got v=%b l=%b n=%0d exp v=1 l=1 n=1", op, a_out_valid, a_out_last, a_out_beats);
      end
    end
    a_in_valid = 1'b0;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL ops_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_and_reduce();
    logic [7:0] ins [3];
    logic [7:0] exps [3];
    ins = '{8'hFF, 8'h0F, 8'h3F};
    exps = '{8'hFF, 8'h0F, 8'h0F};
    a_out_ready = 1'b1; a_in_accum = 1'b1; a_in_op = 3'b000; a_in_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      a_in_a = ins[i]; a_in_last = (i == 2); a_in_valid = 1'b1;
      tick();
      n_checks++; if (a_out_y !== exps[i]) begin n_fail++; $display("FAIL and_y beat=%0d got=%h exp=%h", i, a_out_y, exps[i]); end
      n_checks++; if (a_out_beats !== 8'(i + 1)) begin n_fail++; $display("FAIL and_beats beat=%0d got=%0d exp=%0d", i, a_out_beats, i + 1); end
      n_checks++; if (a_out_last !== (i == 2)) begin n_fail++; $display("FAIL and_last beat=%0d got=%b exp=%b", i, a_out_last, (i == 2)); end
    end
    // accumulator must be back at all-ones for the next frame
    a_in_a = 8'hAA; a_in_last = 1'b1;
    tick();
    n_checks++; if ({a_out_y, a_out_beats} !== {8'hAA, 8'd1}) begin
      n_fail++; $display("FAIL and_acc_reinit got y=%h n=%0d exp y=aa n=1", a_out_y, a_out_beats);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    int accepted = 0, consumed = 0, cycles = 0;
    logic [7:0] next_val = 8'h11;
    logic [7:0] e;
    exp8_q.delete();
    a_in_op = 3'b111; a_in_accum = 1'b0; a_in_last = 1'b1;
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      a_in_a = next_val;
      #1;
      if (cyc > 0) begin
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0", cyc, a_in_ready); end
        n_checks++; if ({a_out_valid, a_out_y, a_out_beats} !== {1'b1, 8'h11, 8'd1}) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b y=%h n=%0d exp v=1 y=11 n=1", cyc, a_out_valid, a_out_y, a_out_beats);
        end
      end
      if (a_in_valid && a_in_ready) begin exp8_q.push_back(a_in_a); accepted++; next_val += 8'h11; end
      tick();
    end
    n_checks++; if (accepted !== 1) begin n_fail++; $display("FAIL bp_accept_count got=%0d exp=1", accepted); end
    a_out_ready = 1'b1;
    while (consumed < 6 && cycles < 40) begin
      a_in_a = next_val; a_in_valid = (accepted < 6);
      #1;
      if (a_out_valid && a_out_ready) begin
        consumed++;
        n_checks++;
        if (exp8_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra got=%h exp=none", a_out_y);
        end else begin
          e = exp8_q.pop_front();
          if (a_out_y !== e) begin n_fail++; $display("FAIL bp_flow_y got=%h exp=%h", a_out_y, e); end
        end
      end
      if (a_in_valid && a_in_ready) begin exp8_q.push_back(a_in_a); accepted++; next_val += 8'h11; end
      tick();
      cycles++;
    end
    n_checks++; if (cycles !== 6) begin n_fail++; $display("FAIL bp_flow_cycles got=%0d exp=6", cycles); end
    n_checks++; if (exp8_q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover got=%0d exp=0", exp8_q.size()); end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    a_out_ready = 1'b1; a_in_accum = 1'b1; a_in_op = 3'b000; a_in_last = 1'b0;
    a_in_valid = 1'b1; a_in_a = 8'hF0;
    tick();
    a_in_a = 8'h3C;
    tick();
    n_checks++; if ({a_out_valid, a_out_y, a_out_beats} !== {1'b1, 8'h30, 8'd2}) begin
      n_fail++; $display("FAIL mid_pre got v=%b y=%h n=%0d exp v=1 y=30 n=2", a_out_valid, a_out_y, a_out_beats);
    end
    a_out_ready = 1'b0; a_in_a = 8'h77; rst = 1'b1;
    tick();
    n_checks++; if ({a_out_valid, a_out_y, a_out_beats} !== {1'b0, 8'h00, 8'd0}) begin
      n_fail++; $display("FAIL mid_rst got v=%b y=%h n=%0d exp v=0 y=00 n=0", a_out_valid, a_out_y, a_out_beats);
    end
    rst = 1'b0; a_in_valid = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", a_in_ready); end
    a_in_a = 8'h5A; a_in_last = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    n_checks++; if ({a_out_y, a_out_beats, a_out_zero} !== {8'h5A, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL mid_after got y=%h n=%0d z=%b exp y=5a n=1 z=0", a_out_y, a_out_beats, a_out_zero);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_n [5];
    exp_n = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    b_out_ready = 1'b1; b_in_op = 3'b111; b_in_accum = 1'b0; b_in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_in_a = 8'(i + 1); b_in_valid = 1'b1;
      tick();
      n_checks++; if (b_out_beats !== exp_n[i]) begin n_fail++; $display("FAIL wrap_beats beat=%0d got=%0d exp=%0d", i, b_out_beats, exp_n[i]); end
    end
    b_in_last = 1'b1;
    tick();
    n_checks++; if ({b_out_beats, b_out_last} !== {2'd2, 1'b1}) begin
      n_fail++; $display("FAIL wrap_last got n=%0d l=%b exp n=2 l=1", b_out_beats, b_out_last);
    end
    b_in_op = 3'b010; b_in_a = 8'h5A; b_in_b = 8'h5A;
    tick();
    n_checks++; if ({b_out_beats, b_out_y, b_out_zero} !== {2'd1, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL wrap_newframe got n=%0d y=%h z=%b exp n=1 y=00 z=1", b_out_beats, b_out_y, b_out_zero);
    end
    b_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [12:0] acc_m = '1;
    logic [7:0]  cnt_m = '0;
    logic [12:0] b_m, r_m, ey;
    logic [EW-1:0] e;
    logic [EW:0] snap;
    logic hold_pend = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    exp_q.delete();
    while (got < NBEATS && cyc < MAX_CYC) begin
      c_in_valid  = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 3) != 0);
      c_in_a      = 13'($urandom_range(0, 8191));
      c_in_b      = 13'($urandom_range(0, 8191));
      c_in_op     = 3'($urandom_range(0, 7));
      c_in_accum  = ($urandom_range(0, 1) == 1);
      c_in_last   = ($urandom_range(0, 4) == 0);
      #1;
      if (hold_pend) begin
        n_checks++;
        if ({c_out_valid, c_out_y, c_out_last, c_out_beats} !== snap) begin
          n_fail++; $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", cyc, {c_out_valid, c_out_y, c_out_last, c_out_beats}, snap);
        end
      end
      if (c_out_valid && c_out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra got y=%h exp=none", c_out_y);
        end else begin
          e = exp_q.pop_front();
          ey = e[21:9];
          if ({c_out_y, c_out_last, c_out_beats} !== e || c_out_zero !== (ey == 13'd0)) begin
            n_fail++; $display("FAIL rnd_beat n=%0d got y=%h l=%b n=%0d z=%b exp y=%h l=%b n=%0d z=%b",
              got, c_out_y, c_out_last, c_out_beats, c_out_zero, ey, e[8], e[7:0], (ey == 13'd0));
          end
        end
      end
      if (c_in_valid && c_in_ready) begin
        b_m = c_in_accum ? acc_m : c_in_b;
        r_m = lop(c_in_op, c_in_a, b_m);
        exp_q.push_back({r_m, c_in_last, 8'(cnt_m + 8'd1)});
        acc_m = c_in_last ? 13'h1FFF : r_m;
        cnt_m = c_in_last ? 8'd0 : cnt_m + 8'd1;
        sent++;
      end
      hold_pend = c_out_valid && !c_out_ready;
      snap = {c_out_valid, c_out_y, c_out_last, c_out_beats};
      tick();
      cyc++;
    end
    n_checks++; if (got !== NBEATS) begin n_fail++; $display("FAIL rnd_timeout got=%0d exp=%0d", got, NBEATS); end
    c_in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ops();
    test_and_reduce();
    test_back_pressure();
    test_reset_mid_frame();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
